burst_data: RTL and testbench

BURST_DATA -- requirements
Module: burst_data

---
 rtl/burst_data.sv | 183 ++++++++++++++++++
 tb/tb_burst_data.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_data.sv
// rtl/burst_data.sv - DDR CAS burst data sequencer with latency tracker
//
// Purpose: queues issued CAS commands, counts each one down to its first data
// cycle, then runs the DQ burst. Write bursts fetch and drive write data.
// Read bursts capture dq_in. Back-to-back bursts run seamlessly.
//
// Ports:
//   clock_t, reset_n       clock, synchronous active-low reset
//   cas_rdy, cas_rw        CAS strobe and command type (READ/WRITE)
//   CL, CWL, BL            read/write latency in clocks, burst length in beats
//   wr_data, wr_pop        write data source handshake (data one cycle after pop)
//   dq_out, dq_oe          write data and output enable toward the DRAM
//   dq_in                  read data from the DRAM
//   rd_data, rd_valid      captured read data, delayed one cycle
//   rw_done                one-cycle pulse after the last cycle of each burst
//   busy                   tracker non-empty or burst in progress
//   ovf_err, col_err       sticky tracker-overflow and burst-collision flags

package ddr_package;
   localparam logic [1:0] READ  = 2'b01;
   localparam logic [1:0] WRITE = 2'b10;
endpackage

module burst_data
   import ddr_package::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic            clock_t,
   input  logic            reset_n,
   input  logic            cas_rdy,
   input  logic [1:0]      cas_rw,
   input  logic [4:0]      CL,
   input  logic [4:0]      CWL,
   input  logic [3:0]      BL,
   input  logic [2*DW-1:0] wr_data,
   input  logic [2*DW-1:0] dq_in,
   output logic            wr_pop,
   output logic [2*DW-1:0] dq_out,
   output logic            dq_oe,
   output logic [2*DW-1:0] rd_data,
   output logic            rd_valid,
   output logic            rw_done,
   output logic            busy,
   output logic            ovf_err,
   output logic            col_err
);

   localparam int OW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {BD_IDLE, BD_BURST} state_t;
   state_t state, state_nx;

   // Tracker kept as a shift queue, index 0 is the head.
   // cnt = clocks left until the entry's first data cycle.
   logic          trk_wr  [DEPTH];
   logic [4:0]    trk_cnt [DEPTH];
   logic [2:0]    trk_len [DEPTH];
   logic          nx_wr   [DEPTH];
   logic [4:0]    nx_cnt  [DEPTH];
   logic [2:0]    nx_len  [DEPTH];
   logic [OW-1:0] occ;
   logic [IW-1:0] wr_idx;

   logic [2:0] left;      // clocks left in the current burst, including this one
   logic       cur_wr;

   logic       cmd_ok, full, push, pop, free, head_due, start;
   logic [4:0] lat, push_cnt;
   logic [2:0] push_len;

   always_comb begin
      cmd_ok   = cas_rdy && (cas_rw == READ || cas_rw == WRITE);
      lat      = (cas_rw == WRITE) ? CWL : CL;
      // Stored one less than the latency: the entry is first seen a cycle after issue.
      push_cnt = (lat == 5'd0) ? 5'd0 : lat - 5'd1;
      push_len = (BL == 4'd4) ? 3'd2 : 3'd4;
      // The burst engine can accept a new head next cycle.
      free     = (state == BD_IDLE) || (left == 3'd1);
      // The head's first data cycle is next cycle, or already overdue.
      head_due = (occ != '0) && (trk_cnt[0] <= 5'd1);
      start    = head_due && free;
      pop      = start;
      full     = (occ == OW'(DEPTH));
      push     = cmd_ok && (!full || pop);
   end

   // Next tracker contents: shift on pop, age every entry, append on push.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         nx_wr[i]  = trk_wr[i];
         nx_cnt[i] = trk_cnt[i];
         nx_len[i] = trk_len[i];
      end
      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            nx_wr[i]  = trk_wr[i+1];
            nx_cnt[i] = trk_cnt[i+1];
            nx_len[i] = trk_len[i+1];
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (nx_cnt[i] != 5'd0) nx_cnt[i] = nx_cnt[i] - 5'd1;
      end
      wr_idx = IW'(occ) - IW'(pop);
      if (push) begin
         nx_wr[wr_idx]  = (cas_rw == WRITE);
         nx_cnt[wr_idx] = push_cnt;
         nx_len[wr_idx] = push_len;
      end
   end

   always_ff @(posedge clock_t) begin
      if (!reset_n) begin
         occ <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            trk_wr[i]  <= 1'b0;
            trk_cnt[i] <= 5'd0;
            trk_len[i] <= 3'd0;
         end
      end else begin
         occ <= occ + OW'(push) - OW'(pop);
         for (int i = 0; i < DEPTH; i++) begin
            trk_wr[i]  <= nx_wr[i];
            trk_cnt[i] <= nx_cnt[i];
            trk_len[i] <= nx_len[i];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clock_t) begin
      if (!reset_n) state <= BD_IDLE;
      else          state <= state_nx;
   end

   // FSM next state: a start in the last burst cycle keeps BD_BURST (seamless)
   always_comb begin
      state_nx = state;
      case (state)
         BD_IDLE:  if (start) state_nx = BD_BURST;
         BD_BURST: if (left == 3'd1 && !start) state_nx = BD_IDLE;
         default:  state_nx = BD_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      dq_oe  = (state == BD_BURST) && cur_wr;
      dq_out = dq_oe ? wr_data : '0;
      // Fetch one word ahead: the cycle before a write burst, and every burst cycle but the last.
      wr_pop = (start && trk_wr[0]) || (dq_oe && left != 3'd1);
      busy   = (occ != '0) || (state == BD_BURST);
   end

   // Burst counter, read capture, completion and error flags
   always_ff @(posedge clock_t) begin
      if (!reset_n) begin
         left     <= 3'd0;
         cur_wr   <= 1'b0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rw_done  <= 1'b0;
         ovf_err  <= 1'b0;
         col_err  <= 1'b0;
      end else begin
         if (start) begin
            left   <= trk_len[0];
            cur_wr <= trk_wr[0];
         end else if (state == BD_BURST) begin
            left <= left - 3'd1;
         end
         rd_valid <= (state == BD_BURST) && !cur_wr;
         if (state == BD_BURST && !cur_wr) rd_data <= dq_in;
         rw_done <= (state == BD_BURST) && (left == 3'd1);
         if (cmd_ok && full && !pop) ovf_err <= 1'b1;
         if (head_due && !free)      col_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_burst_data.sv
// tb/tb_burst_data.sv - self-checking bench for burst_data with a schedule-level model

module tb_burst_data;
   import ddr_package::*;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int AN    = 256;

   logic            clock_t;
   logic            reset_n;
   logic            cas_rdy;
   logic [1:0]      cas_rw;
   logic [4:0]      CL, CWL;
   logic [3:0]      BL;
   logic [2*DW-1:0] wr_data, dq_in, dq_out, rd_data;
   logic            wr_pop, dq_oe, rd_valid, rw_done, busy, ovf_err, col_err;

   burst_data #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clock_t(clock_t), .reset_n(reset_n), .cas_rdy(cas_rdy), .cas_rw(cas_rw),
      .CL(CL), .CWL(CWL), .BL(BL), .wr_data(wr_data), .dq_in(dq_in),
      .wr_pop(wr_pop), .dq_out(dq_out), .dq_oe(dq_oe), .rd_data(rd_data),
      .rd_valid(rd_valid), .rw_done(rw_done), .busy(busy),
      .ovf_err(ovf_err), .col_err(col_err)
   );

   initial clock_t = 1'b0;
   always #5 clock_t = ~clock_t;

   int passed, total;

   // Command list for one scenario
   int         ncmd;
   int         cmd_t  [32];
   logic [1:0] cmd_rw [32];
   int         cmd_l  [32];
   int         cmd_bl [32];

   // Expected per-cycle outputs
   bit e_wp [AN], e_oe [AN], e_rv [AN], e_done [AN], e_busy [AN];
   int e_widx [AN];
   bit e_ovf, e_col;

   // Observed per-cycle outputs: ctl = {wr_pop, dq_oe, rd_valid, rw_done, busy}
   logic [4:0]      o_ctl [AN];
   logic [2*DW-1:0] o_dq [AN], o_rd [AN], dqin_log [AN];
   logic            o_ovf [AN], o_col [AN];
   logic [2*DW-1:0] word_seq [128];

   // Schedule model: each accepted command bursts at max(issue+latency, previous end+1)
   task automatic build_model(input int ncyc, input int rst_c);
      int a_push [32];
      int a_start [32];
      int na, prev_end, occ, due, st, en, k;
      bit wr;
      na = 0; prev_end = -1; e_ovf = 0; e_col = 0;
      for (int c = 0; c < AN; c++) begin
         e_wp[c] = 0; e_oe[c] = 0; e_rv[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_widx[c] = 0;
      end
      for (int i = 0; i < ncmd; i++) begin
         if (cmd_rw[i] != READ && cmd_rw[i] != WRITE) continue;
         occ = 0;
         for (int j = 0; j < na; j++)
            if (a_push[j] + 1 <= cmd_t[i] && a_start[j] - 1 > cmd_t[i]) occ++;
         if (occ >= DEPTH) begin e_ovf = 1; continue; end
         due = cmd_t[i] + cmd_l[i];
         st  = (due > prev_end + 1) ? due : prev_end + 1;
         if (due <= prev_end) e_col = 1;
         en  = st + cmd_bl[i] / 2 - 1;
         wr  = (cmd_rw[i] == WRITE);
         for (int c = cmd_t[i] + 1; c <= en; c++) e_busy[c] = 1;
         for (int c = st; c <= en; c++) begin
            e_oe[c] = wr; e_wp[c-1] = wr; e_rv[c+1] = !wr;
         end
         e_done[en+1] = 1;
         a_push[na] = cmd_t[i]; a_start[na] = st; na++;
         prev_end = en;
      end
      if (rst_c >= 0)
         for (int c = rst_c + 1; c < AN; c++) begin
            e_wp[c] = 0; e_oe[c] = 0; e_rv[c] = 0; e_done[c] = 0; e_busy[c] = 0;
         end
      k = 0;
      for (int c = 0; c < ncyc; c++) if (e_oe[c]) begin e_widx[c] = k; k++; end
   endtask

   // Reset, then drive ncyc cycles of the command list; the bench acts as write-data source
   task automatic run(input int ncyc, input int rst_c);
      int ci, src_k;
      reset_n = 1'b0; cas_rdy = 1'b0; cas_rw = 2'b00; CL = 5'd2; CWL = 5'd2; BL = 4'd8;
      wr_data = '0; dq_in = '0;
      repeat (2) @(posedge clock_t);
      #1;
      ci = 0; src_k = 0;
      for (int c = 0; c < ncyc; c++) begin
         cas_rdy = 1'b0;
         cas_rw  = 2'($urandom);
         CL      = 5'($urandom_range(2, 24));
         CWL     = 5'($urandom_range(2, 24));
         BL      = ($urandom_range(0, 1) == 1) ? 4'd8 : 4'd4;
         if (ci < ncmd && cmd_t[ci] == c) begin
            cas_rdy = 1'b1;
            cas_rw  = cmd_rw[ci];
            if (cmd_rw[ci] == WRITE) CWL = 5'(cmd_l[ci]);
            else                     CL  = 5'(cmd_l[ci]);
            BL = 4'(cmd_bl[ci]);
            ci++;
         end
         if (c > 0 && o_ctl[c-1][4] === 1'b1) begin
            wr_data = word_seq[src_k];
            src_k = (src_k + 1) % 128;
         end else begin
            wr_data = 16'($urandom);
         end
         dq_in   = 16'($urandom);
         reset_n = (c == rst_c) ? 1'b0 : 1'b1;
         @(negedge clock_t);
         o_ctl[c]    = {wr_pop, dq_oe, rd_valid, rw_done, busy};
         o_dq[c]     = dq_out;
         o_rd[c]     = rd_data;
         dqin_log[c] = dq_in;
         o_ovf[c]    = ovf_err;
         o_col[c]    = col_err;
         @(posedge clock_t);
         #1;
      end
      cas_rdy = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      ncmd = 0;
      build_model(6, -1);
      run(6, -1);
      total++;
      if (o_ctl[0] !== 5'b0 || o_dq[0] !== '0 || o_rd[0] !== '0 || o_ovf[0] !== 1'b0 || o_col[0] !== 1'b0)
         $display("FAIL reset_state: ctl=%b dq_out=%h rd_data=%h ovf=%b col=%b, required all 0",
                  o_ctl[0], o_dq[0], o_rd[0], o_ovf[0], o_col[0]);
      else passed++;
      for (int c = 1; c < 6; c++) begin
         total++;
         if (o_ctl[c] !== 5'b0) $display("FAIL reset_idle cyc %0d: ctl=%b required 00000", c, o_ctl[c]);
         else passed++;
      end
   endtask

   task automatic test_write();
      logic [4:0] exp;
      ncmd = 1; cmd_t[0] = 10; cmd_rw[0] = WRITE; cmd_l[0] = 9; cmd_bl[0] = 8;
      build_model(30, -1);
      run(30, -1);
      for (int c = 0; c < 30; c++) begin
         exp = {e_wp[c], e_oe[c], e_rv[c], e_done[c], e_busy[c]};
         total++;
         if (o_ctl[c] !== exp) $display("FAIL write_ctl cyc %0d: ctl=%b required %b", c, o_ctl[c], exp);
         else passed++;
         total++;
         if (o_dq[c] !== (e_oe[c] ? word_seq[e_widx[c]] : 16'h0))
            $display("FAIL write_dq cyc %0d: dq_out=%h required %h", c, o_dq[c],
                     e_oe[c] ? word_seq[e_widx[c]] : 16'h0);
         else passed++;
      end
      total++;
      if (o_ctl[17][4] !== 1'b0 || o_ctl[18][4] !== 1'b1 || o_ctl[21][4] !== 1'b1 || o_ctl[22][4] !== 1'b0 ||
          o_ctl[18][3] !== 1'b0 || o_ctl[19][3] !== 1'b1 || o_ctl[22][3] !== 1'b1 || o_ctl[23][3] !== 1'b0 ||
          o_ctl[23][1] !== 1'b1 || o_ctl[22][1] !== 1'b0)
         $display("FAIL write_timing: wr_pop17/18/21/22=%b%b%b%b oe18/19/22/23=%b%b%b%b done22/23=%b%b, required 0110 0110 01",
                  o_ctl[17][4], o_ctl[18][4], o_ctl[21][4], o_ctl[22][4],
                  o_ctl[18][3], o_ctl[19][3], o_ctl[22][3], o_ctl[23][3], o_ctl[22][1], o_ctl[23][1]);
      else passed++;
   endtask

   task automatic test_read();
      logic [4:0] exp;
      ncmd = 1; cmd_t[0] = 5; cmd_rw[0] = READ; cmd_l[0] = 11; cmd_bl[0] = 4;
      build_model(25, -1);
      run(25, -1);
      for (int c = 0; c < 25; c++) begin
         exp = {e_wp[c], e_oe[c], e_rv[c], e_done[c], e_busy[c]};
         total++;
         if (o_ctl[c] !== exp) $display("FAIL read_ctl cyc %0d: ctl=%b required %b", c, o_ctl[c], exp);
         else passed++;
         if (e_rv[c]) begin
            total++;
            if (o_rd[c] !== dqin_log[c-1])
               $display("FAIL read_data cyc %0d: rd_data=%h required %h", c, o_rd[c], dqin_log[c-1]);
            else passed++;
         end
      end
      total++;
      if (o_ctl[16][2] !== 1'b0 || o_ctl[17][2] !== 1'b1 || o_ctl[18][2] !== 1'b1 || o_ctl[19][2] !== 1'b0 ||
          o_ctl[18][1] !== 1'b1)
         $display("FAIL read_timing: rd_valid16..19=%b%b%b%b done18=%b, required 0110 1",
                  o_ctl[16][2], o_ctl[17][2], o_ctl[18][2], o_ctl[19][2], o_ctl[18][1]);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp;
      ncmd = 2;
      cmd_t[0] = 0; cmd_rw[0] = READ; cmd_l[0] = 11; cmd_bl[0] = 8;
      cmd_t[1] = 4; cmd_rw[1] = READ; cmd_l[1] = 11; cmd_bl[1] = 8;
      build_model(25, -1);
      run(25, -1);
      for (int c = 0; c < 25; c++) begin
         exp = {e_wp[c], e_oe[c], e_rv[c], e_done[c], e_busy[c]};
         total++;
         if (o_ctl[c] !== exp) $display("FAIL b2b_ctl cyc %0d: ctl=%b required %b", c, o_ctl[c], exp);
         else passed++;
      end
      total++;
      if (o_ctl[15][1] !== 1'b1 || o_ctl[19][1] !== 1'b1 || o_ctl[16][1] !== 1'b0 || o_col[24] !== 1'b0)
         $display("FAIL b2b_done: done15=%b done16=%b done19=%b col_err=%b, required 1 0 1 0",
                  o_ctl[15][1], o_ctl[16][1], o_ctl[19][1], o_col[24]);
      else passed++;
   endtask

   task automatic test_overflow();
      logic [4:0] exp;
      int ndone;
      ncmd = 5;
      for (int i = 0; i < 5; i++) begin
         cmd_t[i] = i; cmd_rw[i] = READ; cmd_l[i] = 20; cmd_bl[i] = 8;
      end
      build_model(45, -1);
      run(45, -1);
      ndone = 0;
      for (int c = 0; c < 45; c++) begin
         exp = {e_wp[c], e_oe[c], e_rv[c], e_done[c], e_busy[c]};
         total++;
         if (o_ctl[c] !== exp) $display("FAIL ovf_ctl cyc %0d: ctl=%b required %b", c, o_ctl[c], exp);
         else passed++;
         if (o_ctl[c][1] === 1'b1) ndone++;
      end
      total++;
      if (o_ovf[44] !== 1'b1 || ndone != 4 || o_ovf[4] !== 1'b0 || o_ovf[5] !== 1'b1)
         $display("FAIL ovf_flag: ovf_err=%b (cyc4 %b cyc5 %b) rw_done pulses=%0d, required 1 (0 1) 4",
                  o_ovf[44], o_ovf[4], o_ovf[5], ndone);
      else passed++;
   endtask

   task automatic test_collision();
      logic [4:0] exp;
      ncmd = 2;
      cmd_t[0] = 0; cmd_rw[0] = READ; cmd_l[0] = 11; cmd_bl[0] = 8;
      cmd_t[1] = 2; cmd_rw[1] = READ; cmd_l[1] = 11; cmd_bl[1] = 8;
      build_model(25, -1);
      run(25, -1);
      for (int c = 0; c < 25; c++) begin
         exp = {e_wp[c], e_oe[c], e_rv[c], e_done[c], e_busy[c]};
         total++;
         if (o_ctl[c] !== exp) $display("FAIL col_ctl cyc %0d: ctl=%b required %b", c, o_ctl[c], exp);
         else passed++;
         if (e_rv[c]) begin
            total++;
            if (o_rd[c] !== dqin_log[c-1])
               $display("FAIL col_data cyc %0d: rd_data=%h required %h", c, o_rd[c], dqin_log[c-1]);
            else passed++;
         end
      end
      total++;
      if (o_col[24] !== 1'b1 || o_ctl[19][1] !== 1'b1 || o_ctl[16][2] !== 1'b1 || o_ctl[20][2] !== 1'b0)
         $display("FAIL col_flag: col_err=%b done19=%b rv16=%b rv20=%b, required 1 1 1 0",
                  o_col[24], o_ctl[19][1], o_ctl[16][2], o_ctl[20][2]);
      else passed++;
   endtask

   task automatic test_reset_mid_burst();
      logic [4:0] exp;
      ncmd = 1; cmd_t[0] = 10; cmd_rw[0] = WRITE; cmd_l[0] = 9; cmd_bl[0] = 8;
      build_model(30, 20);
      run(30, 20);
      for (int c = 0; c < 30; c++) begin
         exp = {e_wp[c], e_oe[c], e_rv[c], e_done[c], e_busy[c]};
         total++;
         if (o_ctl[c] !== exp) $display("FAIL rstmid_ctl cyc %0d: ctl=%b required %b", c, o_ctl[c], exp);
         else passed++;
      end
      total++;
      if (o_ctl[21] !== 5'b0 || o_dq[21] !== '0 || o_rd[21] !== '0 || o_ctl[20][3] !== 1'b1)
         $display("FAIL rstmid_after: ctl21=%b dq_out21=%h rd_data21=%h oe20=%b, required 00000 0 0 1",
                  o_ctl[21], o_dq[21], o_rd[21], o_ctl[20][3]);
      else passed++;
   endtask

   task automatic test_random();
      logic [4:0] exp;
      int t, r, ncyc;
      for (int it = 0; it < 6; it++) begin
         ncmd = 6 + $urandom_range(0, 4);
         t = $urandom_range(0, 3);
         for (int i = 0; i < ncmd; i++) begin
            r = $urandom_range(0, 9);
            cmd_t[i]  = t;
            cmd_rw[i] = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r < 6) ? READ : WRITE;
            cmd_l[i]  = $urandom_range(2, 24);
            cmd_bl[i] = ($urandom_range(0, 1) == 1) ? 8 : 4;
            t = t + $urandom_range(1, 6);
         end
         ncyc = cmd_t[ncmd-1] + 70;
         build_model(ncyc, -1);
         run(ncyc, -1);
         for (int c = 0; c < ncyc; c++) begin
            exp = {e_wp[c], e_oe[c], e_rv[c], e_done[c], e_busy[c]};
            total++;
            if (o_ctl[c] !== exp) $display("FAIL rand%0d_ctl cyc %0d: ctl=%b required %b", it, c, o_ctl[c], exp);
            else passed++;
            if (e_oe[c]) begin
               total++;
               if (o_dq[c] !== word_seq[e_widx[c]])
                  $display("FAIL rand%0d_dq cyc %0d: dq_out=%h required %h", it, c, o_dq[c], word_seq[e_widx[c]]);
               else passed++;
            end
            if (e_rv[c]) begin
               total++;
               if (o_rd[c] !== dqin_log[c-1])
                  $display("FAIL rand%0d_rd cyc %0d: rd_data=%h required %h", it, c, o_rd[c], dqin_log[c-1]);
               else passed++;
            end
         end
         total++;
         if (o_ovf[ncyc-1] !== e_ovf || o_col[ncyc-1] !== e_col)
            $display("FAIL rand%0d_flags: ovf_err=%b col_err=%b required %b %b",
                     it, o_ovf[ncyc-1], o_col[ncyc-1], e_ovf, e_col);
         else passed++;
      end
   endtask

   initial begin
      passed = 0; total = 0;
      reset_n = 1'b0; cas_rdy = 1'b0; cas_rw = 2'b00; CL = 5'd2; CWL = 5'd2; BL = 4'd8;
      wr_data = '0; dq_in = '0;
      for (int i = 0; i < 128; i++) word_seq[i] = 16'($urandom);
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_overflow();
      test_collision();
      test_reset_mid_burst();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
